uart_imem_loader: RTL and testbench
===================================

Name: uart_imem_loader

Overview:
Sequences program download into instruction memory. It takes the byte stream from the UART receiver, packs each group of four bytes into a little-endian 32-bit word and writes it to consecutive imem addresses. It holds the core in reset during the download. A terminator word ends the download; the block then asserts write_done and releases the core. It sits in the wrapper between the UART RX and the imem write port.

Parameters:
ADDR_W, 10, imem word-address width; capacity 2**ADDR_W words
TERM_WORD, 32'hFFFF_FFFF, end-of-program marker; it is never written to imem
GAP_TIMEOUT, 1_000_000, clk cycles without a byte before a partial word is discarded; 0 disables the timeout

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
load_en  in  1  when 1, bytes are accepted in IDLE
uart_rx_valid  in  1  one-cycle strobe: uart_rx_data is valid
uart_rx_data  in  8  received byte
uart_rx_break  in  1  BREAK detected; restarts the load
imem_we  out  1  write request; held until accepted
imem_wready  in  1  imem accepts the write in a cycle where imem_we=1 and imem_wready=1
imem_addr  out  ADDR_W  word address
imem_wdata  out  32  word to write
core_rst  out  1  active-high reset to the CPU core
write_done  out  1  program loaded and core released
word_count  out  ADDR_W+1  number of words committed
load_err  out  1  sticky error flag: overflow or overrun

Behaviour:
- Reset values: FSM=IDLE, imem_we=0, imem_addr=0, imem_wdata=0, core_rst=1, write_done=0, word_count=0, load_err=0, byte_idx=0, gap counter=0.
- States are IDLE, COLLECT, DONE and ERR. The write handshake runs alongside COLLECT; a pending flag tracks it.
- IDLE: a strobe with load_en=1 stores the byte in shift[7:0], sets byte_idx=1 and moves to COLLECT. Strobes with load_en=0 are ignored.
- COLLECT byte packing: byte k of a word goes to bits [8k+7:8k].
- COLLECT, word complete: the 4th byte completes the word in the cycle of its strobe.
  - If the word equals TERM_WORD and no write is pending: go to DONE on the next edge.
  - If the word equals TERM_WORD and a write is pending: go to DONE after that write is accepted.
  - Any other word: imem_wdata is loaded with it and imem_we=1 from the next cycle.
- Write handshake:
  - Acceptance happens at an edge where imem_we=1 and imem_wready=1.
  - On that edge: imem_we drops to 0, imem_addr increments and word_count increments.
  - Minimum write latency is 1 cycle from the 4th strobe to imem_we=1.
  - Bytes of the next word keep being collected while a write is pending.
  - If a new word completes while imem_we is still 1: set load_err=1 and go to ERR (overrun).
- Overflow: if a non-terminator word completes when word_count==2**ADDR_W, set load_err=1 and go to ERR. imem_addr never wraps.
- Gap timeout: when byte_idx!=0 and no strobe arrives for GAP_TIMEOUT cycles, byte_idx returns to 0 and the partial bytes are discarded. The address is unchanged. The counter reloads on every strobe.
- DONE: core_rst=0 and write_done=1 from the first cycle in DONE. All strobes are ignored.
- ERR: core_rst=1 and write_done=0. Bytes are ignored.
- uart_rx_break, from any state, takes priority over everything else in the same cycle:
  - The FSM goes to IDLE; imem_addr, word_count and byte_idx are cleared.
  - A pending write is dropped (imem_we=0).
  - core_rst=1 and write_done=0; load_err is cleared.
  - The byte strobed in the same cycle is discarded.
- Priority for simultaneous events: break > write acceptance > byte strobe > gap timeout.
  - A strobe in the same cycle as acceptance is captured normally.
- rst asserted mid-load: all state returns to its reset value immediately; no partial write survives.
- core_rst is a registered output and never glitches.

Decomposition:
- Shared package holds:
  - the state enum: IDLE, COLLECT, DONE, ERR
  - the TERM_WORD default
  - the BYTES_PER_WORD=4 constant
- One sub-module, loader_gap_timer: a loadable down-counter with restart, enable and expired outputs.
- The FSM, byte packer and write port stay in the top module.

Test Plan:
- Load 3 words then the terminator (words 0xfe010113, 0x00112e23, 0x00812c23 sent LSB byte first; imem_wready=1 throughout) -> writes to addr 0,1,2 with those exact data; word_count=3; write_done=1 and core_rst=0 one cycle after the last terminator byte.
- Hold imem_wready=0 for 50 cycles during the first write while the next word's bytes arrive -> imem_we held steadily with stable addr/wdata; no loss; second word written at addr 1.
- Send 2 bytes, idle for GAP_TIMEOUT+5 cycles, then send 0x13,0x00,0x00,0x00 -> partial discarded; addr 0 gets 0x00000013.
- With ADDR_W=2, send 4 data words then a 5th data word -> 4 writes; load_err=1; ERR state; core_rst stays 1.
- Pulse uart_rx_break after 1.5 words, then send 1 word and the terminator -> that word is written at addr 0; write_done=1.
- In DONE, send 4 more bytes and a second 0xFFFFFFFF -> no imem_we; outputs unchanged. Assert rst mid-byte -> all outputs return to reset values immediately (asynchronous).

Source files
------------

// File: rtl/uart_imem_loader_pkg.sv
// Shared types and constants for the UART-to-imem program loader.
package uart_imem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DONE    = 2'd2,
        ERR     = 2'd3
    } load_state_t;

    localparam logic [31:0] TERM_WORD_DEFAULT = 32'hFFFF_FFFF;
    localparam int          BYTES_PER_WORD    = 4;

    // Place byte b into lane idx of a little-endian word.
    function automatic logic [31:0] insert_byte(input logic [31:0] word,
                                                input logic [1:0]  idx,
                                                input logic [7:0]  b);
        logic [31:0] w;
        w = word;
        w[{idx, 3'b000} +: 8] = b;
        return w;
    endfunction

endpackage

// File: rtl/uart_imem_loader_gap_timer.sv
// Inter-byte gap timer: reloads on every byte, counts down while a partial
// word is held, and flags expiry on the last idle cycle. LOAD=0 disables it.
module loader_gap_timer #(
    parameter int LOAD = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic restart,
    input  logic enable,
    output logic expired
);
    localparam int                CNT_W    = (LOAD > 1) ? $clog2(LOAD + 1) : 1;
    localparam logic [CNT_W-1:0]  LOAD_VAL = CNT_W'(LOAD);
    localparam logic [CNT_W-1:0]  ONE      = CNT_W'(1);

    logic [CNT_W-1:0] count;

    // Down-counter: clear wins, then reload on a byte, then decrement while armed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= {CNT_W{1'b0}};
        end else if (clear) begin
            count <= {CNT_W{1'b0}};
        end else if (restart) begin
            count <= LOAD_VAL;
        end else if (enable && (count != {CNT_W{1'b0}})) begin
            count <= count - ONE;
        end else begin
            count <= count;
        end
    end

    assign expired = (LOAD != 0) && enable && !restart && (count == ONE);

endmodule

// File: rtl/uart_imem_loader.sv
// Packs UART bytes into little-endian words, writes them to imem, holds the
// core in reset until a terminator word arrives.
module uart_imem_loader
    import uart_imem_loader_pkg::*;
#(
    parameter int          ADDR_W      = 10,
    parameter logic [31:0] TERM_WORD   = TERM_WORD_DEFAULT,
    parameter int          GAP_TIMEOUT = 1_000_000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic              uart_rx_valid,
    input  logic [7:0]        uart_rx_data,
    input  logic              uart_rx_break,
    output logic              imem_we,
    input  logic              imem_wready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              write_done,
    output logic [ADDR_W:0]   word_count,
    output logic              load_err
);
    localparam logic [ADDR_W:0]   CAPACITY = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]        LAST_IDX = 2'(BYTES_PER_WORD - 1);

    load_state_t       state, state_nxt;
    logic [31:0]       shift, shift_nxt;
    logic [1:0]        byte_idx, byte_idx_nxt;
    logic              term_pending, term_pending_nxt;
    logic              we_nxt, err_nxt, core_rst_nxt, done_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [31:0]       wdata_nxt;
    logic [ADDR_W:0]   count_nxt;

    logic              accept;
    logic              still_pending;
    logic [31:0]       word_full;
    logic [ADDR_W:0]   count_after;
    logic              gap_expired;

    assign accept        = imem_we & imem_wready;
    assign still_pending = imem_we & ~imem_wready;
    assign word_full     = insert_byte(shift, byte_idx, uart_rx_data);
    assign count_after   = accept ? (word_count + CNT_ONE) : word_count;

    loader_gap_timer #(.LOAD(GAP_TIMEOUT)) u_gap_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (uart_rx_break),
        .restart (uart_rx_valid),
        .enable  ((state == COLLECT) && (byte_idx != 2'd0) && !term_pending),
        .expired (gap_expired)
    );

    // Next-state logic: break, then write acceptance, then byte strobe, then gap timeout.
    always_comb begin
        state_nxt        = state;
        shift_nxt        = shift;
        byte_idx_nxt     = byte_idx;
        term_pending_nxt = term_pending;
        we_nxt           = imem_we;
        addr_nxt         = imem_addr;
        wdata_nxt        = imem_wdata;
        count_nxt        = word_count;
        err_nxt          = load_err;
        if (uart_rx_break) begin
            state_nxt        = IDLE;
            shift_nxt        = 32'h0000_0000;
            byte_idx_nxt     = 2'd0;
            term_pending_nxt = 1'b0;
            we_nxt           = 1'b0;
            addr_nxt         = {ADDR_W{1'b0}};
            count_nxt        = {(ADDR_W+1){1'b0}};
            err_nxt          = 1'b0;
        end else begin
            if (accept) begin
                we_nxt    = 1'b0;
                count_nxt = word_count + CNT_ONE;
                // Saturate so the address never wraps back over word 0.
                if (imem_addr != ADDR_MAX) begin
                    addr_nxt = imem_addr + ADDR_ONE;
                end else begin
                    addr_nxt = imem_addr;
                end
            end else begin
                we_nxt = imem_we;
            end
            case (state)
                IDLE: begin
                    if (uart_rx_valid && load_en) begin
                        shift_nxt    = {24'h00_0000, uart_rx_data};
                        byte_idx_nxt = 2'd1;
                        state_nxt    = COLLECT;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
                COLLECT: begin
                    if (term_pending) begin
                        // Terminator seen; finish only once the last data word lands.
                        if (accept) begin
                            term_pending_nxt = 1'b0;
                            state_nxt        = DONE;
                        end else begin
                            state_nxt = COLLECT;
                        end
                    end else if (uart_rx_valid) begin
                        if (byte_idx == LAST_IDX) begin
                            byte_idx_nxt = 2'd0;
                            shift_nxt    = word_full;
                            if (word_full == TERM_WORD) begin
                                if (still_pending) begin
                                    term_pending_nxt = 1'b1;
                                end else begin
                                    state_nxt = DONE;
                                end
                            end else if (still_pending || (count_after == CAPACITY)) begin
                                err_nxt   = 1'b1;
                                state_nxt = ERR;
                            end else begin
                                wdata_nxt = word_full;
                                we_nxt    = 1'b1;
                            end
                        end else begin
                            shift_nxt    = word_full;
                            byte_idx_nxt = byte_idx + 2'd1;
                        end
                    end else if (gap_expired) begin
                        byte_idx_nxt = 2'd0;
                    end else begin
                        state_nxt = COLLECT;
                    end
                end
                DONE:    state_nxt = DONE;
                ERR:     state_nxt = ERR;
                default: state_nxt = IDLE;
            endcase
        end
        core_rst_nxt = (state_nxt != DONE);
        done_nxt     = (state_nxt == DONE);
    end

    // State and output registers; core_rst/write_done are registered so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            shift        <= 32'h0000_0000;
            byte_idx     <= 2'd0;
            term_pending <= 1'b0;
            imem_we      <= 1'b0;
            imem_addr    <= {ADDR_W{1'b0}};
            imem_wdata   <= 32'h0000_0000;
            word_count   <= {(ADDR_W+1){1'b0}};
            load_err     <= 1'b0;
            core_rst     <= 1'b1;
            write_done   <= 1'b0;
        end else begin
            state        <= state_nxt;
            shift        <= shift_nxt;
            byte_idx     <= byte_idx_nxt;
            term_pending <= term_pending_nxt;
            imem_we      <= we_nxt;
            imem_addr    <= addr_nxt;
            imem_wdata   <= wdata_nxt;
            word_count   <= count_nxt;
            load_err     <= err_nxt;
            core_rst     <= core_rst_nxt;
            write_done   <= done_nxt;
        end
    end

endmodule

// File: tb/tb_uart_imem_loader.sv
// Scoreboard bench for uart_imem_loader: expected writes are queued by the
// stimulus, a negedge monitor pops and compares on every accepted write.
module tb_uart_imem_loader;
    localparam int AW  = 2;
    localparam int GAP = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load_en = 1'b1;
    logic          uart_rx_valid = 1'b0;
    logic [7:0]    uart_rx_data = 8'h00;
    logic          uart_rx_break = 1'b0;
    logic          imem_wready = 1'b1;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          core_rst;
    logic          write_done;
    logic [AW:0]   word_count;
    logic          load_err;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;
    wr_t exp_q[$];
    wr_t got;

    uart_imem_loader #(.ADDR_W(AW), .TERM_WORD(32'hFFFF_FFFF), .GAP_TIMEOUT(GAP)) dut (
        .clk(clk), .rst(rst), .load_en(load_en),
        .uart_rx_valid(uart_rx_valid), .uart_rx_data(uart_rx_data),
        .uart_rx_break(uart_rx_break), .imem_we(imem_we), .imem_wready(imem_wready),
        .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst(core_rst),
        .write_done(write_done), .word_count(word_count), .load_err(load_err)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Monitor: every accepted write must match the head of the expected queue.
    always @(negedge clk) begin
        if (!rst && imem_we && imem_wready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_write: got addr %0d data %h, required no write",
                         imem_addr, imem_wdata);
            end else begin
                got = exp_q.pop_front();
                check("write_addr", 32'(imem_addr), 32'(got.addr));
                check("write_data", imem_wdata, got.data);
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        uart_rx_valid = 1'b1;
        uart_rx_data  = b;
        tick();
        uart_rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic expect_write(input logic [AW-1:0] a, input logic [31:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        uart_rx_valid = 1'b0;
        uart_rx_break = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    logic stable;

    initial begin
        // Reset values
        do_reset();
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_count", 32'(word_count), 32'd0);
        check("rst_core_rst", 32'(core_rst), 32'd1);
        check("rst_done", 32'(write_done), 32'd0);
        check("rst_err", 32'(load_err), 32'd0);

        // Three words then terminator
        expect_write(2'd0, 32'hfe01_0113);
        expect_write(2'd1, 32'h0011_2e23);
        expect_write(2'd2, 32'h0081_2c23);
        send_word(32'hfe01_0113);
        send_word(32'h0011_2e23);
        send_word(32'h0081_2c23);
        send_word(32'hFFFF_FFFF);
        check("t1_done", 32'(write_done), 32'd1);
        check("t1_core_rst", 32'(core_rst), 32'd0);
        check("t1_count", 32'(word_count), 32'd3);
        drain("t1_drain");

        // Back-pressure for 50 cycles while the next word arrives
        do_reset();
        imem_wready = 1'b0;
        expect_write(2'd0, 32'h1234_5678);
        expect_write(2'd1, 32'h0011_2e23);
        send_word(32'h1234_5678);
        send_byte(8'h23);
        send_byte(8'h2e);
        send_byte(8'h11);
        stable = 1'b1;
        for (int i = 0; i < 44; i++) begin
            tick();
            if (!(imem_we === 1'b1 && imem_addr === 2'd0 && imem_wdata === 32'h1234_5678))
                stable = 1'b0;
        end
        check("t2_stall_hold", 32'(stable), 32'd1);
        imem_wready = 1'b1;
        send_byte(8'h00);
        send_word(32'hFFFF_FFFF);
        drain("t2_drain");
        check("t2_count", 32'(word_count), 32'd2);
        check("t2_done", 32'(write_done), 32'd1);

        // Gap timeout discards a partial word
        do_reset();
        send_byte(8'hAA);
        send_byte(8'hBB);
        repeat (GAP + 5) tick();
        expect_write(2'd0, 32'h0000_0013);
        send_word(32'h0000_0013);
        drain("t3_drain");
        check("t3_count", 32'(word_count), 32'd1);
        check("t3_err", 32'(load_err), 32'd0);

        // Overflow with a 4-word imem
        do_reset();
        for (int i = 0; i < 4; i++) begin
            expect_write(AW'(i), 32'h0000_0100 + 32'(i));
            send_word(32'h0000_0100 + 32'(i));
        end
        send_word(32'h0000_0200);
        drain("t4_drain");
        check("t4_err", 32'(load_err), 32'd1);
        check("t4_core_rst", 32'(core_rst), 32'd1);
        check("t4_done", 32'(write_done), 32'd0);
        check("t4_count", 32'(word_count), 32'd4);

        // Break after 1.5 words restarts the load at address 0
        do_reset();
        expect_write(2'd0, 32'h1122_3344);
        send_word(32'h1122_3344);
        send_byte(8'h55);
        send_byte(8'h66);
        tick();
        uart_rx_break = 1'b1;
        tick();
        uart_rx_break = 1'b0;
        check("t5_brk_count", 32'(word_count), 32'd0);
        expect_write(2'd0, 32'hA5A5_0F0F);
        send_word(32'hA5A5_0F0F);
        send_word(32'hFFFF_FFFF);
        drain("t5_drain");
        check("t5_done", 32'(write_done), 32'd1);
        check("t5_count", 32'(word_count), 32'd1);
        check("t5_core_rst", 32'(core_rst), 32'd0);

        // Bytes in DONE are ignored
        send_word(32'h0403_0201);
        send_word(32'hFFFF_FFFF);
        repeat (4) tick();
        check("t6_done", 32'(write_done), 32'd1);
        check("t6_count", 32'(word_count), 32'd1);
        check("t6_we", 32'(imem_we), 32'd0);

        // Asynchronous reset with a write pending and a partial word
        do_reset();
        imem_wready = 1'b0;
        send_word(32'hDEAD_BEEF);
        send_byte(8'h77);
        check("t7_pending", 32'(imem_we), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("t7_we", 32'(imem_we), 32'd0);
        check("t7_addr", 32'(imem_addr), 32'd0);
        check("t7_wdata", imem_wdata, 32'd0);
        check("t7_count", 32'(word_count), 32'd0);
        check("t7_core_rst", 32'(core_rst), 32'd1);
        tick();
        rst = 1'b0;
        imem_wready = 1'b1;
        repeat (5) tick();
        check("t7_no_write", 32'(imem_we), 32'd0);
        check("final_queue", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
